// File: rtl/router_cfg_pkg.sv
// Shared types and constants for the router own-address configuration sequencer.
package router_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_X    = 3'd1,
        GET_Y    = 3'd2,
        GET_CSUM = 3'd3,
        COMMIT   = 3'd4,
        ERR      = 3'd5
    } cfg_state_e;

    localparam logic [7:0] CFG_HDR     = 8'hA5;
    localparam int         CFG_TIMEOUT = 16;

    // Frame checksum: header XOR both coordinate bytes.
    function automatic logic [7:0] cfg_csum(input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic [7:0] hdr = CFG_HDR);
        return hdr ^ x ^ y;
    endfunction

endpackage

// File: rtl/cfg_timeout_cnt.sv
// Inter-byte idle counter; expired flags the last permitted idle cycle.
module cfg_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count idle cycles, clear takes priority, never wrap past the last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LAST);

endmodule

// File: rtl/router_addr_cfg_ctrl.sv
// Validates framed config bytes (header, X, Y, checksum) and issues a single
// write pulse to the router's own-address registers.
module router_addr_cfg_ctrl
    import router_cfg_pkg::*;
#(
    parameter int         COORD_W = 4,
    parameter int         TIMEOUT = CFG_TIMEOUT,
    parameter logic [7:0] HDR     = CFG_HDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid_i,
    input  logic [7:0]         cfg_data_i,
    output logic               cfg_ready_o,
    output logic               addr_we_o,
    output logic [COORD_W-1:0] addr_x_o,
    output logic [COORD_W-1:0] addr_y_o,
    output logic               cfg_done_o,
    output logic               cfg_err_o,
    output logic [7:0]         cfg_count_o
);
    cfg_state_e state_r;
    logic [7:0] x_r;
    logic [7:0] y_r;
    logic       accept_s;
    logic       in_frame_s;
    logic       expired_s;
    logic       frame_ok_s;

    assign accept_s   = cfg_valid_i && cfg_ready_o;
    assign in_frame_s = (state_r == GET_X) || (state_r == GET_Y) || (state_r == GET_CSUM);
    assign frame_ok_s = (cfg_data_i == cfg_csum(x_r, y_r, HDR))
                        && ((x_r >> COORD_W) == 8'd0)
                        && ((y_r >> COORD_W) == 8'd0);

    cfg_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept_s || !in_frame_s),
        .inc     (in_frame_s && !accept_s),
        .expired (expired_s)
    );

    // Frame FSM; outputs are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            x_r         <= 8'd0;
            y_r         <= 8'd0;
            cfg_ready_o <= 1'b1;
            addr_we_o   <= 1'b0;
            addr_x_o    <= {COORD_W{1'b0}};
            addr_y_o    <= {COORD_W{1'b0}};
            cfg_done_o  <= 1'b0;
            cfg_err_o   <= 1'b0;
            cfg_count_o <= 8'd0;
        end else begin
            cfg_ready_o <= 1'b1;
            addr_we_o   <= 1'b0;
            addr_x_o    <= {COORD_W{1'b0}};
            addr_y_o    <= {COORD_W{1'b0}};
            cfg_done_o  <= 1'b0;
            cfg_err_o   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && (cfg_data_i == HDR)) begin
                        state_r <= GET_X;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GET_X, GET_Y: begin
                    if (accept_s) begin
                        if (state_r == GET_X) begin
                            x_r     <= cfg_data_i;
                            state_r <= GET_Y;
                        end else begin
                            y_r     <= cfg_data_i;
                            state_r <= GET_CSUM;
                        end
                    end else if (expired_s) begin
                        state_r     <= ERR;
                        cfg_err_o   <= 1'b1;
                        cfg_ready_o <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                GET_CSUM: begin
                    if (accept_s && frame_ok_s) begin
                        state_r     <= COMMIT;
                        addr_we_o   <= 1'b1;
                        addr_x_o    <= x_r[COORD_W-1:0];
                        addr_y_o    <= y_r[COORD_W-1:0];
                        cfg_done_o  <= 1'b1;
                        cfg_ready_o <= 1'b0;
                    end else if (accept_s || expired_s) begin
                        state_r     <= ERR;
                        cfg_err_o   <= 1'b1;
                        cfg_ready_o <= 1'b0;
                    end else begin
                        state_r <= GET_CSUM;
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                    if (cfg_count_o != 8'hFF) begin
                        cfg_count_o <= cfg_count_o + 8'd1;
                    end else begin
                        cfg_count_o <= cfg_count_o;
                    end
                end
                ERR: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_addr_cfg_ctrl.sv
// Directed self-checking bench for router_addr_cfg_ctrl.
module tb_router_addr_cfg_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid_i;
    logic [7:0] cfg_data_i;
    logic       cfg_ready_o;
    logic       addr_we_o;
    logic [3:0] addr_x_o;
    logic [3:0] addr_y_o;
    logic       cfg_done_o;
    logic       cfg_err_o;
    logic [7:0] cfg_count_o;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int rdy_low_cnt = 0;
    int stall_cnt = 0;

    router_addr_cfg_ctrl #(.COORD_W(4), .TIMEOUT(16), .HDR(8'hA5)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid_i),
        .cfg_data_i  (cfg_data_i),
        .cfg_ready_o (cfg_ready_o),
        .addr_we_o   (addr_we_o),
        .addr_x_o    (addr_x_o),
        .addr_y_o    (addr_y_o),
        .cfg_done_o  (cfg_done_o),
        .cfg_err_o   (cfg_err_o),
        .cfg_count_o (cfg_count_o)
    );

    always #5 clk = ~clk;

    // Pulse and stall counters, sampled with pre-edge values.
    always @(posedge clk) begin
        if (!rst) begin
            if (addr_we_o)   we_cnt++;
            if (cfg_done_o)  done_cnt++;
            if (cfg_err_o)   err_cnt++;
            if (!cfg_ready_o) rdy_low_cnt++;
            if (cfg_valid_i && !cfg_ready_o) stall_cnt++;
        end
    end

    task automatic clear_counts();
        we_cnt = 0; done_cnt = 0; err_cnt = 0; rdy_low_cnt = 0; stall_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one byte from a negedge; return at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        bit r;
        int n;
        n = 0;
        cfg_valid_i = 1'b1;
        cfg_data_i  = b;
        forever begin
            r = cfg_ready_o;
            @(posedge clk);
            if (r) break;
            @(negedge clk);
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_byte_timeout: byte %h not accepted within 50 cycles", b);
                break;
            end
        end
        @(negedge clk);
        cfg_valid_i = 1'b0;
        cfg_data_i  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    endtask

    // Expect the commit cycle right now with given coordinates.
    task automatic expect_commit(input string name, input logic [3:0] ex, input logic [3:0] ey);
        checks++;
        if (addr_we_o !== 1'b1 || cfg_done_o !== 1'b1 || cfg_ready_o !== 1'b0 ||
            addr_x_o !== ex || addr_y_o !== ey || cfg_err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: we=%b done=%b rdy=%b err=%b x=%h y=%h, required we=1 done=1 rdy=0 err=0 x=%h y=%h",
                     name, addr_we_o, cfg_done_o, cfg_ready_o, cfg_err_o, addr_x_o, addr_y_o, ex, ey);
        end
    endtask

    task automatic expect_err_now(input string name);
        checks++;
        if (cfg_err_o !== 1'b1 || addr_we_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: err=%b we=%b rdy=%b, required err=1 we=0 rdy=0",
                     name, cfg_err_o, addr_we_o, cfg_ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid_i = 1'b0; cfg_data_i = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++;
        if (cfg_ready_o !== 1'b1 || addr_we_o !== 1'b0 || cfg_done_o !== 1'b0 ||
            cfg_err_o !== 1'b0 || cfg_count_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b we=%b done=%b err=%b count=%0d, required 1 0 0 0 0",
                     cfg_ready_o, addr_we_o, cfg_done_o, cfg_err_o, cfg_count_o);
        end
    endtask

    task automatic test_good_frame();
        clear_counts();
        send_frame(8'hA5, 8'h03, 8'h05, 8'hA3);
        expect_commit("good_frame", 4'd3, 4'd5);
        idle(1);
        checks++;
        if (addr_we_o !== 1'b0 || cfg_ready_o !== 1'b1 || cfg_count_o !== 8'd1) begin
            errors++;
            $display("FAIL good_frame_after: we=%b rdy=%b count=%0d, required 0 1 1",
                     addr_we_o, cfg_ready_o, cfg_count_o);
        end
        idle(3);
        checks++;
        if (we_cnt != 1 || done_cnt != 1 || err_cnt != 0 || rdy_low_cnt != 1) begin
            errors++;
            $display("FAIL good_frame_pulses: we=%0d done=%0d err=%0d rdy_low=%0d, required 1 1 0 1",
                     we_cnt, done_cnt, err_cnt, rdy_low_cnt);
        end
    endtask

    task automatic test_bad_csum();
        clear_counts();
        send_frame(8'hA5, 8'h03, 8'h05, 8'h00);
        expect_err_now("bad_csum");
        idle(3);
        checks++;
        if (err_cnt != 1 || we_cnt != 0 || cfg_count_o !== 8'd1) begin
            errors++;
            $display("FAIL bad_csum_pulses: err=%0d we=%0d count=%0d, required 1 0 1",
                     err_cnt, we_cnt, cfg_count_o);
        end
        send_frame(8'hA5, 8'h01, 8'h02, 8'hA6);
        expect_commit("after_bad_csum", 4'd1, 4'd2);
        idle(1);
        checks++;
        if (cfg_count_o !== 8'd2) begin
            errors++;
            $display("FAIL after_bad_csum_count: count=%0d, required 2", cfg_count_o);
        end
    endtask

    task automatic test_range();
        clear_counts();
        send_frame(8'hA5, 8'h13, 8'h05, 8'hB3);
        expect_err_now("range_x");
        idle(3);
        checks++;
        if (we_cnt != 0 || err_cnt != 1 || cfg_count_o !== 8'd2) begin
            errors++;
            $display("FAIL range_pulses: we=%0d err=%0d count=%0d, required 0 1 2",
                     we_cnt, err_cnt, cfg_count_o);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_byte(8'hA5); send_byte(8'h03);
        // Now in idle cycle 1; advance to idle cycle 16.
        idle(15);
        checks++;
        if (cfg_err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err=%b at idle cycle 16, required 0", cfg_err_o);
        end
        idle(1);
        expect_err_now("timeout_expire");
        idle(3);
        clear_counts();
        send_byte(8'hA5); send_byte(8'h03);
        idle(15);
        send_byte(8'h05);
        send_byte(8'hA3);
        expect_commit("timeout_boundary", 4'd3, 4'd5);
        idle(2);
        checks++;
        if (err_cnt != 0 || cfg_count_o !== 8'd3) begin
            errors++;
            $display("FAIL timeout_boundary_err: err=%0d count=%0d, required 0 3", err_cnt, cfg_count_o);
        end
    endtask

    task automatic test_reset_and_junk();
        clear_counts();
        send_byte(8'hA5); send_byte(8'h03);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        checks++;
        if (we_cnt != 0 || err_cnt != 0 || done_cnt != 0 || cfg_count_o !== 8'd0 || cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset: we=%0d err=%0d done=%0d count=%0d rdy=%b, required 0 0 0 0 1",
                     we_cnt, err_cnt, done_cnt, cfg_count_o, cfg_ready_o);
        end
        send_frame(8'hA5, 8'h02, 8'h02, 8'hA5);
        expect_commit("after_reset", 4'd2, 4'd2);
        idle(2);
        clear_counts();
        send_byte(8'h00); send_byte(8'hFF);
        idle(20);
        checks++;
        if (err_cnt != 0 || we_cnt != 0) begin
            errors++;
            $display("FAIL junk_dropped: err=%0d we=%0d, required 0 0", err_cnt, we_cnt);
        end
        send_frame(8'hA5, 8'h01, 8'h02, 8'hA6);
        expect_commit("after_junk", 4'd1, 4'd2);
        idle(1);
        checks++;
        if (cfg_count_o !== 8'd2) begin
            errors++;
            $display("FAIL after_junk_count: count=%0d, required 2", cfg_count_o);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] x, y;
        clear_counts();
        for (int i = 0; i < 256; i++) begin
            x = 8'(i % 16);
            y = 8'((i * 3) % 16);
            send_byte(8'hA5);
            idle($urandom_range(0, 10));
            send_byte(x);
            idle($urandom_range(0, 10));
            send_byte(y);
            idle($urandom_range(0, 10));
            // Next header is offered during the commit cycle to exercise backpressure.
            send_byte(8'hA5 ^ x ^ y);
        end
        idle(3);
        checks++;
        if (cfg_count_o !== 8'd255 || we_cnt != 256 || err_cnt != 0) begin
            errors++;
            $display("FAIL saturation: count=%0d we=%0d err=%0d, required 255 256 0",
                     cfg_count_o, we_cnt, err_cnt);
        end
        clear_counts();
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h01);
        cfg_valid_i = 1'b1;
        cfg_data_i  = 8'hA5 ^ 8'h07 ^ 8'h01;
        @(posedge clk);
        @(negedge clk);
        cfg_data_i  = 8'hA5;
        idle(2);
        cfg_valid_i = 1'b0;
        idle(3);
        checks++;
        if (stall_cnt != 1 || we_cnt != 1 || cfg_count_o !== 8'd255) begin
            errors++;
            $display("FAIL backpressure: stalls=%0d we=%0d count=%0d, required 1 1 255",
                     stall_cnt, we_cnt, cfg_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_range();
        test_timeout();
        test_reset_and_junk();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
